prism_sp_cookie_feeder: RTL and testbench
=========================================

PRISM_SP_COOKIE_FEEDER -- requirements
Module: prism_sp_cookie_feeder

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 64, raw cookie width.
REQ-002 SHALL have parameter DATA_OUT_WIDTH, default 64, converted cookie width.
REQ-003 SHALL have parameter CONVERT_LATENCY, default 0, converter pipeline depth in cycles (0..15).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, at least 2).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clock, input, 1, sole clock.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, descriptor-completion event valid.
REQ-009 SHALL have port in_ready, output, 1, event accepted.
REQ-010 SHALL have port in_cookie, input, DATA_IN_WIDTH, raw cookie from the descriptor.
REQ-011 SHALL have port in_desc_addr, input, SYSTEM_ADDR_WIDTH, descriptor address.
REQ-012 SHALL have port cv, prism_sp_cookie_convert_interface.master, driving data_in and dma_desc_cur and sampling data_out.
REQ-013 SHALL have port out_valid, output, 1, converted result available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-015 SHALL have port out_data, output, DATA_OUT_WIDTH, converted cookie.
REQ-016 SHALL have port out_desc_addr, output, SYSTEM_ADDR_WIDTH, matching descriptor address.
REQ-017 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-018 SHALL have port busy, output, 1, high when the FSM is not in IDLE or fifo_count is non-zero.

Function
REQ-019 SHALL implement an FSM with states IDLE, CONVERT and PUSH.
REQ-020 SHALL drive in_ready = 1 only in IDLE.
REQ-021 SHALL, in IDLE on in_valid && in_ready, register in_cookie into cv.data_in and in_desc_addr into cv.dma_desc_cur.
REQ-022 SHALL, on that same acceptance, load lat_cnt with CONVERT_LATENCY and enter CONVERT.
REQ-023 SHALL hold cv.data_in and cv.dma_desc_cur stable from capture until the state returns to IDLE.
REQ-024 SHALL, in CONVERT with lat_cnt != 0, decrement lat_cnt.
REQ-025 SHALL, in CONVERT with lat_cnt == 0, sample cv.data_out together with cv.dma_desc_cur as the result.
REQ-026 SHALL push the result into the FIFO and go to IDLE if a push is permitted, else hold the result and go to PUSH.
REQ-027 SHALL, in PUSH, push the held result and go to IDLE in the first cycle a push is permitted.
REQ-028 SHALL permit a push when fifo_count < FIFO_DEPTH, or when fifo_count == FIFO_DEPTH and out_ready && out_valid in the same cycle.
REQ-029 SHALL give latency from acceptance at cycle T to earliest out_valid at T+2+CONVERT_LATENCY with an empty FIFO, and throughput of at most one event per 2+CONVERT_LATENCY cycles.
REQ-030 SHALL operate the FIFO first-word-fall-through: out_valid = (fifo_count != 0), with out_data/out_desc_addr taken from the head entry.
REQ-031 SHALL pop the FIFO on out_valid && out_ready.
REQ-032 SHALL, on simultaneous push and pop, leave fifo_count unchanged and preserve order.
REQ-033 SHALL wrap the read/write pointers modulo FIFO_DEPTH.
REQ-034 SHALL treat a pop on empty as impossible (out_valid low) and a push on full without pop as impossible (REQ-028).
REQ-035 SHALL hold out_data and out_desc_addr stable while out_valid && !out_ready.

Reset
REQ-036 SHALL, on resetn assertion, asynchronously force state IDLE, lat_cnt 0, fifo_count 0, pointers 0, cv.data_in 0, cv.dma_desc_cur 0, out_valid 0, busy 0.
REQ-037 SHALL hold in_ready at 0 while resetn is low and at 1 from the first clock edge after release.
REQ-038 SHALL discard any in-flight conversion and all FIFO contents on reset mid-operation.
REQ-039 SHALL release reset synchronously to clock; the external reset synchroniser provides this.

Structure
REQ-040 SHALL take SYSTEM_ADDR_WIDTH and the FSM state typedef from prism_sp_pkg.
REQ-041 SHALL place the FIFO in one sub-module, prism_sp_cookie_fifo, parameterised by width and depth.

Verification
REQ-042 SHALL cover single event with CONVERT_LATENCY=0 and identity converter: cookie 0xDEAD_BEEF, addr 0x1000 accepted at T -> out_valid at T+2 with out_data 0xDEAD_BEEF and out_desc_addr 0x1000.
REQ-043 SHALL cover latency 3: event accepted at T -> in_ready low T+1..T+4, out_valid at T+5.
REQ-044 SHALL cover backpressure with out_ready=0 and FIFO_DEPTH=4: 6 events -> fifo_count 4, FSM in PUSH, in_ready 0, busy 1; then out_ready=1 -> all 6 delivered in order.
REQ-045 SHALL cover full with simultaneous pop: fifo_count 4, push permitted in the same cycle as a pop -> fifo_count stays 4, no loss.
REQ-046 SHALL cover reset asserted in CONVERT with 2 FIFO entries -> next cycle out_valid 0, fifo_count 0, in_ready 1 after release.
REQ-047 SHALL cover random valid/ready over 10k events against a scoreboard -> zero mismatches and order preserved.

Source files
------------

// File: rtl/prism_sp_pkg.sv
// rtl/prism_sp_pkg.sv - shared address width and feeder FSM state type
package prism_sp_pkg;

  localparam int SYSTEM_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PUSH    = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/prism_sp_cookie_convert_interface.sv
// rtl/prism_sp_cookie_convert_interface.sv - feeder to cookie converter link
interface prism_sp_cookie_convert_interface #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 64
);
  logic [DATA_IN_WIDTH-1:0]                   data_in;
  logic [prism_sp_pkg::SYSTEM_ADDR_WIDTH-1:0] dma_desc_cur;
  logic [DATA_OUT_WIDTH-1:0]                  data_out;

  modport master (output data_in, output dma_desc_cur, input data_out);
  modport slave  (input data_in, input dma_desc_cur, output data_out);
endinterface

// File: rtl/prism_sp_cookie_fifo.sv
// rtl/prism_sp_cookie_fifo.sv - first-word-fall-through result FIFO
module prism_sp_cookie_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // When full, a simultaneous push overwrites the slot being read this cycle.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/prism_sp_cookie_feeder.sv
// rtl/prism_sp_cookie_feeder.sv - feeds completion cookies through the converter into a result FIFO
module prism_sp_cookie_feeder
  import prism_sp_pkg::*;
#(
  parameter int DATA_IN_WIDTH   = 64,
  parameter int DATA_OUT_WIDTH  = 64,
  parameter int CONVERT_LATENCY = 0,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_IN_WIDTH-1:0]      in_cookie,
  input  logic [SYSTEM_ADDR_WIDTH-1:0]  in_desc_addr,
  prism_sp_cookie_convert_interface.master cv,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_OUT_WIDTH-1:0]     out_data,
  output logic [SYSTEM_ADDR_WIDTH-1:0]  out_desc_addr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = DATA_OUT_WIDTH + SYSTEM_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       LAT_INIT   = 4'(CONVERT_LATENCY);

  feeder_state_t                state, state_nxt;
  logic [3:0]                   lat_cnt;
  logic                         ready_en;
  logic [DATA_IN_WIDTH-1:0]     data_in_q;
  logic [SYSTEM_ADDR_WIDTH-1:0] desc_q;
  logic [ENTRY_W-1:0]           held_q;
  logic [ENTRY_W-1:0]           push_data;
  logic [ENTRY_W-1:0]           head;
  logic                         accept, push, pop, push_ok, conv_done;

  assign cv.data_in      = data_in_q;
  assign cv.dma_desc_cur = desc_q;

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push_ok   = (fifo_count < FULL_COUNT) || pop;
  assign conv_done = (state == ST_CONVERT) && (lat_cnt == 4'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_CONVERT;
      ST_CONVERT: if (lat_cnt == 4'd0) state_nxt = push_ok ? ST_IDLE : ST_PUSH;
      ST_PUSH:    if (push_ok) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    push      = 1'b0;
    push_data = held_q;
    case (state)
      ST_IDLE: in_ready = ready_en;
      ST_CONVERT: begin
        if (lat_cnt == 4'd0) begin
          push      = push_ok;
          push_data = {cv.data_out, desc_q};
        end
      end
      ST_PUSH: push = push_ok;
      default: ;
    endcase
  end

  // ready_en keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_en  <= 1'b0;
      lat_cnt   <= 4'd0;
      data_in_q <= '0;
      desc_q    <= '0;
      held_q    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        data_in_q <= in_cookie;
        desc_q    <= in_desc_addr;
        lat_cnt   <= LAT_INIT;
      end else if ((state == ST_CONVERT) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (conv_done) held_q <= {cv.data_out, desc_q};
    end
  end

  prism_sp_cookie_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign out_valid     = (fifo_count != '0);
  assign out_data      = head[ENTRY_W-1:SYSTEM_ADDR_WIDTH];
  assign out_desc_addr = head[SYSTEM_ADDR_WIDTH-1:0];
  assign busy          = (state != ST_IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_prism_sp_cookie_feeder.sv
// tb/tb_prism_sp_cookie_feeder.sv - directed and random scoreboard bench for the cookie feeder
module tb_prism_sp_cookie_feeder;
  import prism_sp_pkg::*;

  logic        clock;
  logic        resetn;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_cookie, out_data;
  logic [31:0] in_desc_addr, out_desc_addr;
  logic [2:0]  fifo_count;

  logic        in_valid_3, in_ready_3, out_valid_3, out_ready_3, busy_3;
  logic [63:0] in_cookie_3, out_data_3;
  logic [31:0] in_desc_addr_3, out_desc_addr_3;
  logic [2:0]  fifo_count_3;

  prism_sp_cookie_convert_interface #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(64)) cv0 ();
  prism_sp_cookie_convert_interface #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(64)) cv3 ();
  assign cv0.data_out = cv0.data_in;
  assign cv3.data_out = cv3.data_in;

  prism_sp_cookie_feeder #(
    .DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(64), .CONVERT_LATENCY(0), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cookie(in_cookie), .in_desc_addr(in_desc_addr),
    .cv(cv0.master),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_desc_addr(out_desc_addr),
    .fifo_count(fifo_count), .busy(busy)
  );

  prism_sp_cookie_feeder #(
    .DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(64), .CONVERT_LATENCY(3), .FIFO_DEPTH(4)
  ) dut3 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid_3), .in_ready(in_ready_3),
    .in_cookie(in_cookie_3), .in_desc_addr(in_desc_addr_3),
    .cv(cv3.master),
    .out_valid(out_valid_3), .out_ready(out_ready_3),
    .out_data(out_data_3), .out_desc_addr(out_desc_addr_3),
    .fifo_count(fifo_count_3), .busy(busy_3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef logic [95:0] entry_t;
  entry_t sb[$];
  int n_eval = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: observe handshakes at the falling edge, then advance to just after the rising edge.
  task automatic tick(output bit acc);
    entry_t exp;
    @(negedge clock);
    acc = in_valid && in_ready;
    if (acc) sb.push_back({in_cookie, in_desc_addr});
    if (out_valid && out_ready) begin
      chk("pop_has_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("out_entry", 128'({out_data, out_desc_addr}), 128'(exp));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] c, input logic [31:0] a);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_cookie = c;
    in_desc_addr = a;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", 128'(acc), 128'(1));
  endtask

  initial begin
    bit acc;
    int n;
    int accepted;
    resetn = 1'b0;
    in_valid = 1'b0; in_cookie = '0; in_desc_addr = '0; out_ready = 1'b1;
    in_valid_3 = 1'b0; in_cookie_3 = '0; in_desc_addr_3 = '0; out_ready_3 = 1'b1;

    // Reset state
    @(posedge clock); #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_fifo_count", 128'(fifo_count), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cv_data_in", 128'(cv0.data_in), 128'(0));
    resetn = 1'b1;
    chk("rel_in_ready_before_edge", 128'(in_ready), 128'(0));
    tick(acc);
    chk("rel_in_ready_after_edge", 128'(in_ready), 128'(1));

    // Single event, latency 0
    send(64'hDEAD_BEEF, 32'h1000);
    chk("l0_t1_in_ready", 128'(in_ready), 128'(0));
    chk("l0_t1_out_valid", 128'(out_valid), 128'(0));
    chk("l0_t1_cv_hold", 128'(cv0.data_in), 128'(64'hDEAD_BEEF));
    tick(acc);
    chk("l0_t2_out_valid", 128'(out_valid), 128'(1));
    chk("l0_t2_out_data", 128'(out_data), 128'(64'hDEAD_BEEF));
    chk("l0_t2_out_addr", 128'(out_desc_addr), 128'(32'h1000));
    tick(acc);
    chk("l0_drained_count", 128'(fifo_count), 128'(0));
    chk("l0_drained_busy", 128'(busy), 128'(0));

    // Latency 3 on the second instance
    in_valid_3 = 1'b1; in_cookie_3 = 64'h0123_4567_89AB_CDEF; in_desc_addr_3 = 32'h3000;
    chk("l3_accept_ready", 128'(in_ready_3), 128'(1));
    tick(acc);
    in_valid_3 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("l3_t%0d_in_ready", k), 128'(in_ready_3), 128'(0));
      chk($sformatf("l3_t%0d_out_valid", k), 128'(out_valid_3), 128'(0));
      tick(acc);
    end
    chk("l3_t5_out_valid", 128'(out_valid_3), 128'(1));
    chk("l3_t5_out_data", 128'(out_data_3), 128'(64'h0123_4567_89AB_CDEF));
    chk("l3_t5_out_addr", 128'(out_desc_addr_3), 128'(32'h3000));
    tick(acc);

    // Backpressure: five accepted, sixth stalls with FSM holding a result
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(64'h100 + 64'(i), 32'h2000 + 32'(i * 16));
    in_valid = 1'b1; in_cookie = 64'h105; in_desc_addr = 32'h2050;
    for (int i = 0; i < 3; i++) tick(acc);
    chk("bp_fifo_count", 128'(fifo_count), 128'(4));
    chk("bp_state_push", 128'(dut.state), 128'(ST_PUSH));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_busy", 128'(busy), 128'(1));
    chk("bp_head", 128'(out_data), 128'(64'h100));
    out_ready = 1'b1;
    tick(acc);
    chk("full_pop_push_count", 128'(fifo_count), 128'(4));
    chk("full_pop_push_no_accept", 128'(acc), 128'(0));
    n = 0;
    while (!acc && n < 20) begin tick(acc); n++; end
    in_valid = 1'b0;
    chk("bp_sixth_accepted", 128'(acc), 128'(1));
    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin tick(acc); n++; end
    chk("bp_all_delivered", 128'(sb.size()), 128'(0));
    chk("bp_fifo_empty", 128'(fifo_count), 128'(0));

    // Reset while converting with two FIFO entries
    out_ready = 1'b0;
    send(64'hA1, 32'h4000);
    send(64'hB2, 32'h4010);
    send(64'hC3, 32'h4020);
    chk("rm_fifo_count_pre", 128'(fifo_count), 128'(2));
    chk("rm_state_convert", 128'(dut.state), 128'(ST_CONVERT));
    resetn = 1'b0;
    #1;
    chk("rm_async_out_valid", 128'(out_valid), 128'(0));
    chk("rm_async_fifo_count", 128'(fifo_count), 128'(0));
    chk("rm_async_in_ready", 128'(in_ready), 128'(0));
    sb.delete();
    @(posedge clock); #1;
    chk("rm_next_out_valid", 128'(out_valid), 128'(0));
    chk("rm_next_busy", 128'(busy), 128'(0));
    resetn = 1'b1;
    tick(acc);
    chk("rm_release_in_ready", 128'(in_ready), 128'(1));
    chk("rm_release_fifo_count", 128'(fifo_count), 128'(0));

    // Random valid/ready traffic
    accepted = 0;
    n = 0;
    while (accepted < 10000 && n < 80000) begin
      if (!in_valid && ($urandom_range(0, 9) < 7)) begin
        in_valid = 1'b1;
        in_cookie = {$urandom(), $urandom()};
        in_desc_addr = $urandom();
      end
      out_ready = ($urandom_range(0, 9) < 8);
      tick(acc);
      n++;
      if (acc) begin
        accepted++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin tick(acc); n++; end
    chk("rand_accepted", 128'(accepted), 128'(10000));
    chk("rand_sb_empty", 128'(sb.size()), 128'(0));
    chk("rand_fifo_empty", 128'(fifo_count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
